branch_pht_port_scheduler: RTL and testbench

//  Owns the single-port gshare pattern history table (PHT) and global history register (GHR).

---
 rtl/branch_pht_port_scheduler_if.sv | 37 +++
 rtl/branch_pht_port_scheduler.sv | 128 ++++++++++++
 tb/tb_branch_pht_port_scheduler.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_pht_port_scheduler_if.sv
// Port bundle between the gshare PHT port scheduler, its prediction/update requesters
// and the single-port PHT storage.
interface branch_pht_port_scheduler_if #(
  parameter int PHT_SIZE = 2048
) ();
  localparam int IDX_W = $clog2(PHT_SIZE);

  logic             pred_req_val;
  logic             pred_req_rdy;
  logic [31:0]      pred_req_pc;
  logic             pred_resp_val;
  logic             pred_resp_rdy;
  logic             pred_resp_taken;
  logic             upd_req_val;
  logic             upd_req_rdy;
  logic [31:0]      upd_req_pc;
  logic             upd_req_taken;
  logic [IDX_W-1:0] pht_addr;
  logic [1:0]       pht_rdata;
  logic             pht_wen;
  logic [1:0]       pht_wdata;
  logic             busy;

  modport slave (
    input  pred_req_val, pred_req_pc, pred_resp_rdy,
           upd_req_val, upd_req_pc, upd_req_taken, pht_rdata,
    output pred_req_rdy, pred_resp_val, pred_resp_taken,
           upd_req_rdy, pht_addr, pht_wen, pht_wdata, busy
  );

  modport master (
    output pred_req_val, pred_req_pc, pred_resp_rdy,
           upd_req_val, upd_req_pc, upd_req_taken, pht_rdata,
    input  pred_req_rdy, pred_resp_val, pred_resp_taken,
           upd_req_rdy, pht_addr, pht_wen, pht_wdata, busy
  );
endinterface

// File: rtl/branch_pht_port_scheduler.sv
// Gshare PHT/GHR owner that shares one PHT port between fetch predictions and
// queued two-cycle read-modify-write counter updates, with bounded update starvation.
module branch_pht_port_scheduler #(
  parameter int PHT_SIZE     = 2048,
  parameter int GHR_BITS     = $clog2(PHT_SIZE),
  parameter int UQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  branch_pht_port_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(PHT_SIZE);
  localparam int PTR_W = $clog2(UQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, UPD_RD, UPD_WR} state_e;

  state_e              state_q;
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [SC_W-1:0]     starveCnt_q, starveCnt_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wrPtr_q, rdPtr_q;
  logic                respFull_q, respTaken_q;
  logic [1:0]          ctr_q;

  // Queue keeps only the PC index bits; the GHR is folded in when the entry is serviced.
  logic [IDX_W-1:0]    uqIdx_q   [UQ_DEPTH];
  logic                uqTaken_q [UQ_DEPTH];

  logic             uqFull, uqEmpty, updGo, predFire, push, pop, headTaken;
  logic [IDX_W-1:0] predIdx, headIdx;
  logic [1:0]       ctrNext;
  logic             unusedPcBits;

  assign unusedPcBits = ^{bus.pred_req_pc[31:IDX_W+2], bus.pred_req_pc[1:0],
                          bus.upd_req_pc[31:IDX_W+2], bus.upd_req_pc[1:0], bus.pht_rdata[0]};

  assign uqFull    = (count_q == CNT_W'(UQ_DEPTH));
  assign uqEmpty   = (count_q == '0);
  assign headTaken = uqTaken_q[rdPtr_q];
  assign headIdx   = uqIdx_q[rdPtr_q] ^ ghr_q;
  assign predIdx   = bus.pred_req_pc[IDX_W+1:2] ^ ghr_q;

  assign updGo = (state_q == IDLE) && !uqEmpty &&
                 (!bus.pred_req_val || (respFull_q && !bus.pred_resp_rdy) ||
                  (starveCnt_q == SC_W'(STARVE_LIMIT)));

  assign bus.pred_req_rdy    = (state_q == IDLE) && !updGo && (!respFull_q || bus.pred_resp_rdy);
  assign predFire            = bus.pred_req_val && bus.pred_req_rdy;
  assign bus.pred_resp_val   = respFull_q;
  assign bus.pred_resp_taken = respTaken_q;
  assign bus.upd_req_rdy     = !uqFull;
  assign bus.busy            = (state_q != IDLE) || !uqEmpty;
  assign push                = bus.upd_req_val && !uqFull;
  assign pop                 = (state_q == UPD_WR);

  // A write held off by reset is what makes a mid-RMW reset abandon the update.
  assign bus.pht_wen   = (state_q == UPD_WR) && !reset;
  assign bus.pht_wdata = ctrNext;

  always_comb begin
    bus.pht_addr = '0;
    if (state_q != IDLE) bus.pht_addr = headIdx;
    else if (predFire)   bus.pht_addr = predIdx;
  end

  always_comb begin
    ctrNext = ctr_q;
    if (headTaken && ctr_q != 2'b11)       ctrNext = ctr_q + 2'b01;
    else if (!headTaken && ctr_q != 2'b00) ctrNext = ctr_q - 2'b01;
  end

  always_comb begin
    ghr_d = ghr_q;
    if (state_q == UPD_WR) ghr_d = {ghr_q[GHR_BITS-2:0], headTaken};
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    starveCnt_d = starveCnt_q;
    if (updGo) starveCnt_d = '0;
    else if (predFire && !uqEmpty && starveCnt_q != SC_W'(STARVE_LIMIT))
      starveCnt_d = starveCnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ghr_q       <= '0;
      starveCnt_q <= '0;
      count_q     <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      respFull_q  <= 1'b0;
      respTaken_q <= 1'b0;
      ctr_q       <= 2'b00;
    end else begin
      case (state_q)
        IDLE:    if (updGo) state_q <= UPD_RD;
        UPD_RD: begin
          state_q <= UPD_WR;
          ctr_q   <= bus.pht_rdata;
        end
        UPD_WR:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      ghr_q       <= ghr_d;
      count_q     <= count_d;
      starveCnt_q <= starveCnt_d;
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      if (predFire) begin
        respFull_q  <= 1'b1;
        respTaken_q <= bus.pht_rdata[1];
      end else if (bus.pred_resp_rdy) begin
        respFull_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      uqIdx_q[wrPtr_q]   <= bus.upd_req_pc[IDX_W+1:2];
      uqTaken_q[wrPtr_q] <= bus.upd_req_taken;
    end
  end
endmodule

// File: tb/tb_branch_pht_port_scheduler.sv
// Directed bench for the PHT port scheduler: a bench-owned PHT array, a response
// scoreboard and an update scoreboard carrying its own GHR.
module tb_branch_pht_port_scheduler;
  localparam int PHT_SIZE = 2048;
  localparam int IDX_W    = 11;
  localparam int UQ_DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
  } upd_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  logic [1:0]       mem [PHT_SIZE];
  logic [IDX_W-1:0] mghr = '0;
  upd_t             mq[$];
  logic             respQ[$];
  logic             pendValid = 1'b0;
  logic [IDX_W-1:0] pendAddr  = '0;
  logic [1:0]       pendData  = 2'b00;

  branch_pht_port_scheduler_if #(.PHT_SIZE(PHT_SIZE)) ifc ();

  branch_pht_port_scheduler #(
    .PHT_SIZE(PHT_SIZE), .GHR_BITS(IDX_W), .UQ_DEPTH(UQ_DEPTH), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc)
  );

  assign ifc.pht_rdata = mem[ifc.pht_addr];

  always #5 clk = ~clk;

  function automatic logic [IDX_W-1:0] idxOf(input logic [31:0] pc, input logic [IDX_W-1:0] g);
    return pc[IDX_W+1:2] ^ g;
  endfunction

  function automatic logic [1:0] satNext(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd3) ? c : c + 2'd1;
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard step, taken once per cycle while inputs are stable before the next edge.
  task automatic checkOutput();
    logic [IDX_W-1:0] a;
    logic [1:0]       c;
    upd_t             h;
    expectEq("resp_val", ifc.pred_resp_val, respQ.size() != 0);
    if (ifc.pred_resp_val === 1'b1 && respQ.size() != 0) begin
      expectEq("resp_taken", ifc.pred_resp_taken, respQ[0]);
      if (ifc.pred_resp_rdy) void'(respQ.pop_front());
    end
    if (ifc.pred_req_val && ifc.pred_req_rdy === 1'b1 && !reset) begin
      a = idxOf(ifc.pred_req_pc, mghr);
      expectEq("pred_addr", ifc.pht_addr, a);
      respQ.push_back(mem[a][1]);
    end
    expectEq("upd_rdy", ifc.upd_req_rdy, mq.size() < UQ_DEPTH);
    if (ifc.pht_wen === 1'b1 && !reset) begin
      if (mq.size() == 0) begin
        expectEq("pht_wen", ifc.pht_wen, 0);
      end else begin
        h = mq.pop_front();
        a = idxOf(h.pc, mghr);
        c = satNext(mem[a], h.taken);
        expectEq("rmw_addr", ifc.pht_addr, a);
        expectEq("rmw_wdata", ifc.pht_wdata, c);
        mghr      = {mghr[IDX_W-2:0], h.taken};
        pendValid = 1'b1;
        pendAddr  = ifc.pht_addr;
        pendData  = ifc.pht_wdata;
      end
    end
    if (ifc.upd_req_val && ifc.upd_req_rdy === 1'b1 && !reset) begin
      h.pc    = ifc.upd_req_pc;
      h.taken = ifc.upd_req_taken;
      mq.push_back(h);
    end
    if (reset) begin
      mq.delete();
      respQ.delete();
      mghr      = '0;
      pendValid = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic [31:0] ppc, input logic rr,
                               input logic uv, input logic [31:0] upc, input logic ut);
    @(negedge clk);
    if (pendValid) begin
      mem[pendAddr] = pendData;
      pendValid     = 1'b0;
    end
    ifc.pred_req_val  = pv;
    ifc.pred_req_pc   = ppc;
    ifc.pred_resp_rdy = rr;
    ifc.upd_req_val   = uv;
    ifc.upd_req_pc    = upc;
    ifc.upd_req_taken = ut;
    #1;
    checkOutput();
  endtask

  task automatic idleUntilWen(input int budget, input string tag);
    int n = 0;
    do begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      n++;
    end while (ifc.pht_wen !== 1'b1 && n < budget);
    expectEq({tag, "_wen"}, ifc.pht_wen, 1);
  endtask

  initial begin
    int fires;
    int n;
    for (int i = 0; i < PHT_SIZE; i++) mem[i] = 2'b01;
    ifc.pred_req_val  = 1'b0;
    ifc.pred_req_pc   = '0;
    ifc.pred_resp_rdy = 1'b1;
    ifc.upd_req_val   = 1'b0;
    ifc.upd_req_pc    = '0;
    ifc.upd_req_taken = 1'b0;
    $display("[TB] start");

    // Reset state
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    expectEq("rst_pred_rdy", ifc.pred_req_rdy, 1);
    expectEq("rst_upd_rdy", ifc.upd_req_rdy, 1);
    expectEq("rst_resp_val", ifc.pred_resp_val, 0);
    expectEq("rst_wen", ifc.pht_wen, 0);
    expectEq("rst_busy", ifc.busy, 0);
    reset = 1'b0;
    applyStimulus(0, 0, 1, 0, 0, 0);

    // Single prediction, latency 1
    applyStimulus(1, 32'h200, 1, 0, 0, 0);
    expectEq("pred_fire_addr", ifc.pht_addr, 11'h080);
    applyStimulus(0, 0, 1, 0, 0, 0);
    expectEq("pred_lat_val", ifc.pred_resp_val, 1);
    expectEq("pred_lat_taken", ifc.pred_resp_taken, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);

    // One update with no predictions competing
    applyStimulus(0, 0, 1, 1, 32'h200, 1);
    applyStimulus(0, 0, 1, 0, 0, 0);
    expectEq("upd_go_busy", ifc.busy, 1);
    expectEq("upd_go_addr", ifc.pht_addr, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    expectEq("upd_rd_addr", ifc.pht_addr, 11'h080);
    expectEq("upd_rd_wen", ifc.pht_wen, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    expectEq("upd_wr_wen", ifc.pht_wen, 1);
    expectEq("upd_wr_addr", ifc.pht_addr, 11'h080);
    expectEq("upd_wr_wdata", ifc.pht_wdata, 2'b10);
    applyStimulus(1, 32'h200, 1, 0, 0, 0);
    expectEq("ghr_pred_addr", ifc.pht_addr, 11'h081);
    expectEq("post_upd_busy", ifc.busy, 0);
    applyStimulus(1, 32'h204, 1, 0, 0, 0);
    expectEq("b2b_rdy", ifc.pred_req_rdy, 1);
    expectEq("b2b_taken0", ifc.pred_resp_taken, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    expectEq("b2b_taken1", ifc.pred_resp_taken, 1);

    // Counter saturation at both ends
    mem[11'h101] = 2'b11;
    mem[11'h203] = 2'b00;
    applyStimulus(0, 0, 1, 1, 32'h400, 1);
    applyStimulus(0, 0, 1, 1, 32'h800, 0);
    idleUntilWen(6, "sat_hi");
    expectEq("sat_hi_addr", ifc.pht_addr, 11'h101);
    expectEq("sat_hi_wdata", ifc.pht_wdata, 2'b11);
    idleUntilWen(6, "sat_lo");
    expectEq("sat_lo_addr", ifc.pht_addr, 11'h203);
    expectEq("sat_lo_wdata", ifc.pht_wdata, 2'b00);
    applyStimulus(0, 0, 1, 0, 0, 0);

    // Starvation limit under continuous predictions
    applyStimulus(1, 32'h1000, 1, 1, 32'h300, 1);
    fires = 0;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1, 32'h1000 + 32'(4 * i), 1, 0, 0, 0);
      if (ifc.pred_req_rdy !== 1'b1) break;
      fires++;
    end
    expectEq("starve_fires", fires, 4);
    applyStimulus(1, 32'h1100, 1, 0, 0, 0);
    expectEq("starve_rd_rdy", ifc.pred_req_rdy, 0);
    expectEq("starve_rd_wen", ifc.pht_wen, 0);
    applyStimulus(1, 32'h1104, 1, 0, 0, 0);
    expectEq("starve_wr_rdy", ifc.pred_req_rdy, 0);
    expectEq("starve_wr_wen", ifc.pht_wen, 1);
    applyStimulus(1, 32'h1108, 1, 0, 0, 0);
    expectEq("starve_resume_rdy", ifc.pred_req_rdy, 1);
    applyStimulus(0, 0, 1, 0, 0, 0);

    // Queue fill under predictions, then response backpressure
    applyStimulus(1, 32'h2000, 1, 1, 32'h1100, 1);
    applyStimulus(1, 32'h2004, 1, 1, 32'h2200, 0);
    applyStimulus(1, 32'h2008, 1, 1, 32'h3300, 1);
    applyStimulus(1, 32'h200c, 1, 1, 32'h4400, 1);
    applyStimulus(1, 32'h2010, 1, 1, 32'h5500, 0);
    expectEq("full_upd_rdy", ifc.upd_req_rdy, 0);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1, 32'h2100 + 32'(4 * i), 0, 0, 0, 0);
      expectEq("bp_pred_rdy", ifc.pred_req_rdy, 0);
      expectEq("bp_resp_val", ifc.pred_resp_val, 1);
    end
    applyStimulus(0, 0, 1, 0, 0, 0);
    n = 0;
    do begin
      applyStimulus(0, 0, 1, 0, 0, 0);
      n++;
    end while (ifc.busy !== 1'b0 && n < 10);
    expectEq("drain_busy", ifc.busy, 0);
    expectEq("drain_upd_rdy", ifc.upd_req_rdy, 1);

    // Backpressure with an empty update queue
    applyStimulus(1, 32'h5000, 0, 0, 0, 0);
    expectEq("bpe_first_rdy", ifc.pred_req_rdy, 1);
    applyStimulus(1, 32'h5004, 0, 0, 0, 0);
    expectEq("bpe_hold_rdy", ifc.pred_req_rdy, 0);
    applyStimulus(1, 32'h5008, 1, 0, 0, 0);
    expectEq("bpe_swap_rdy", ifc.pred_req_rdy, 1);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);

    // Reset during the write cycle of an RMW
    applyStimulus(0, 0, 1, 1, 32'h600, 1);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    reset = 1'b1;
    applyStimulus(0, 0, 1, 0, 0, 0);
    expectEq("rst_rmw_wen", ifc.pht_wen, 0);
    reset = 1'b0;
    applyStimulus(0, 0, 1, 0, 0, 0);
    expectEq("rst_rmw_busy", ifc.busy, 0);
    applyStimulus(1, 32'h600, 1, 0, 0, 0);
    expectEq("rst_rmw_addr", ifc.pht_addr, 11'h180);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
